rotator_rr_arbiter: RTL and testbench

- Shares one DW-bit rotate-right datapath among NREQ requesters using round-robin arbitration with valid/ready handshakes.
- Each accepted request's data is rotated right by its amount; the result is registered into a one-deep output buffer tagged with the requester index.
- Sits between multiple client FSMs (e.g. display/pattern generators) and a single shared rotator, so the rotator logic is not replicated per client.

---
 rtl/rotator_rr_arbiter.sv | 116 +++++++++++
 tb/tb_rotator_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotator_rr_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath among NREQ clients.
// Optional ROTATOR_ARB_STATS_EN adds a saturating stall_cnt output.
module rotator_rr_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int AW   = $clog2(DW),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [IW-1:0]     rsp_id,
  input  logic              rsp_ready,
  output logic              busy
`ifdef ROTATOR_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            found;
  logic [IW-1:0]   gnt_id;
  logic [DW-1:0]   sel_data;
  logic [AW-1:0]   sel_amt;
  logic [DW-1:0]   rot;
  logic            can_accept;
  logic            xfer;

  // Scan from ptr, wrapping; first pending requester wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IW'(idx);
      end
    end
  end

  assign sel_data = req_data[int'(gnt_id)*DW +: DW];
  assign sel_amt  = req_amt[int'(gnt_id)*AW +: AW];
  assign rot      = DW'({sel_data, sel_data} >> sel_amt);

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign xfer       = found && can_accept && reset_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rot;
      rsp_id_d    = gnt_id;
      ptr_d       = (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid_q || (|req_valid);

`ifdef ROTATOR_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (rsp_valid_q && !rsp_ready && (|req_valid)
                 && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rotator_rr_arbiter.sv
// Self-checking bench for rotator_rr_arbiter (NREQ=4, DW=8).
// Directed vectors, corner sequences and a randomized reference model.
module tb_rotator_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ*AW-1:0]  req_amt;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [IW-1:0]       rsp_id;
  logic                rsp_ready;
  logic                busy;
`ifdef ROTATOR_ARB_STATS_EN
  logic [15:0]         stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  rotator_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef ROTATOR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  data;
    logic [2:0]  amt;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotr(input logic [7:0] x,
                                      input int k);
    logic [7:0] r;
    for (int j = 0; j < DW; j++) r[j] = x[(j + k) % DW];
    return r;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d,
                         input logic [2:0] a);
    req_data[i*DW +: DW] = d;
    req_amt[i*AW +: AW]  = a;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reference model state
  logic       m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;

  vec_t vecs[6];

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    do_reset();

    // Reset state and idle after release
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data",  rsp_data,  0);
    chk("rst_id",    rsp_id,    0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy",  busy,      0);
    repeat (3) tick();
    chk("idle_valid", rsp_valid, 0);
    chk("idle_ready", req_ready, 0);

    // Async reset with buffer full
    set_req(0, 8'h5A, 3'd1);
    req_valid = 4'b0001;
    tick();
    chk("pre_rst_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1;
    chk("pre_rst_ready", req_ready, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("async_valid", rsp_valid, 0);
    chk("async_data",  rsp_data,  0);
    chk("async_ready", req_ready, 0);
    tick();
    reset_n   = 1'b1;
    req_valid = '0;
    tick();
    chk("post_rst_valid", rsp_valid, 0);

    // Single request
    set_req(2, 8'b1000_0001, 3'd3);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("single_valid", rsp_valid, 1);
    chk("single_data",  rsp_data,  8'b0011_0000);
    chk("single_id",    rsp_id,    2);
    tick();
    chk("pop_valid", rsp_valid, 0);
    chk("pop_data",  rsp_data,  8'b0011_0000);

    // Round robin, all requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 8'(8'h11 * (i + 1)), 3'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("rr_grant%0d", n), req_ready,
          32'(1) << (n % NREQ));
      tick();
      chk($sformatf("rr_valid%0d", n), rsp_valid, 1);
      chk($sformatf("rr_id%0d", n), rsp_id, n % NREQ);
      chk($sformatf("rr_data%0d", n), rsp_data,
          rotr(8'(8'h11 * ((n % NREQ) + 1)), (n % NREQ) + 1));
    end
    req_valid = '0;
    tick();

    // Backpressure with id=1 buffered, then req 3 granted on release
    do_reset();
    set_req(1, 8'hF0, 3'd2);
    set_req(3, 8'h0F, 3'd1);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b1000;
    chk("bp_full_id", rsp_id, 1);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp_ready%0d", n), req_ready, 0);
      chk($sformatf("bp_data%0d", n), rsp_data, 8'h3C);
      tick();
    end
    chk("bp_hold_valid", rsp_valid, 1);
    chk("bp_hold_id", rsp_id, 1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("bp_nobubble_valid", rsp_valid, 1);
    chk("bp_new_id",   rsp_id,   3);
    chk("bp_new_data", rsp_data, 8'h87);
    tick();

    // Table vectors: boundary rotate amounts
    vecs[0] = '{id: 0, data: 8'hA5, amt: 3'd0, exp: 8'hA5};
    vecs[1] = '{id: 1, data: 8'h01, amt: 3'd7, exp: 8'h02};
    vecs[2] = '{id: 2, data: 8'h3C, amt: 3'd4, exp: 8'hC3};
    vecs[3] = '{id: 3, data: 8'h80, amt: 3'd7, exp: 8'h01};
    vecs[4] = '{id: 0, data: 8'h01, amt: 3'd1, exp: 8'h80};
    vecs[5] = '{id: 2, data: 8'hB4, amt: 3'd2, exp: 8'h2D};
    rsp_ready = 1'b1;
    foreach (vecs[v]) begin
      req_valid = '0;
      set_req(vecs[v].id, vecs[v].data, vecs[v].amt);
      req_valid[vecs[v].id] = 1'b1;
      tick();
      chk($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp);
      chk($sformatf("vec%0d_id", v), rsp_id, vecs[v].id);
    end
    req_valid = '0;
    tick();

    // Randomized run against the reference model
    do_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_ptr   = 0;
    for (int c = 0; c < 400; c++) begin
      int         g;
      logic       can;
      logic [3:0] exp_rdy;
      req_valid = 4'($urandom);
      req_data  = 32'($urandom);
      req_amt   = 12'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ])
          g = (m_ptr + k) % NREQ;
      can     = !m_valid || rsp_ready;
      exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'd0;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_busy", busy, m_valid || (req_valid != 0));
      tick();
      if (exp_rdy != 0) begin
        m_valid = 1'b1;
        m_data  = rotr(req_data[g*DW +: DW], int'(req_amt[g*AW +: AW]));
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      chk("rnd_valid", rsp_valid, m_valid);
      chk("rnd_data",  rsp_data,  m_data);
      chk("rnd_id",    rsp_id,    m_id);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

`ifdef ROTATOR_ARB_STATS_EN
    do_reset();
    chk("stall_rst", stall_cnt, 0);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    repeat (10) tick();
    chk("stall_hold", stall_cnt, 16'hFFFF);
    req_valid = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
